// File: rtl/cdr_pkg.sv
// Shared types for the CDR phase controller: phase-detector decision
// encodings, the controller state type and the signed window vote.
package cdr_pkg;

  // Phase-detector decision. 2'b11 has no meaning of its own and is treated as "none".
  typedef logic [1:0] dec_t;
  localparam dec_t DEC_NONE  = 2'b00;
  localparam dec_t DEC_LATE  = 2'b01;
  localparam dec_t DEC_EARLY = 2'b10;

  // Controller state
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACQUIRE = 2'd1;
  localparam state_t ST_TRACK   = 2'd2;

  // Window vote, one of -1 / 0 / +1
  typedef logic signed [1:0] vote_t;
  localparam vote_t VOTE_ZERO = 2'sb00;
  localparam vote_t VOTE_POS  = 2'sb01;
  localparam vote_t VOTE_NEG  = 2'sb11;

endpackage

// File: rtl/cdr_phase_ctrl_if.sv
// Decision / phase-code bus between the phase detector side and the CDR
// phase controller.
//   en, dec_valid, decision : loop enable and qualified early/late decisions
//   pi_code, pi_code_valid  : registered interpolator code and its update pulse
//   locked                  : high while the loop is in TRACK
interface cdr_phase_ctrl_if #(
  parameter int unsigned CODE_W = 7
);
  import cdr_pkg::*;

  logic              en;
  logic              dec_valid;
  dec_t              decision;
  logic [CODE_W-1:0] pi_code;
  logic              pi_code_valid;
  logic              locked;

  modport master (
    output en, dec_valid, decision,
    input  pi_code, pi_code_valid, locked
  );

  modport slave (
    input  en, dec_valid, decision,
    output pi_code, pi_code_valid, locked
  );
endinterface

// File: rtl/cdr_vote_window.sv
// Collects VOTE_LEN qualified decisions into a signed vote accumulator and
// reports the window result.
//   clk, rst     : clock, asynchronous active-high reset
//   i_en         : loop enable; low clears the partial window
//   i_dec_valid  : decision qualifier
//   i_decision   : early / late / none
//   o_close      : one-cycle pulse the cycle after the window closed
//   o_vote       : sign of the final accumulator (valid with o_close)
//   o_full       : |final accumulator| == VOTE_LEN (valid with o_close)
module cdr_vote_window
  import cdr_pkg::*;
#(
  parameter int unsigned VOTE_LEN = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  logic  i_dec_valid,
  input  dec_t  i_decision,
  output logic  o_close,
  output vote_t o_vote,
  output logic  o_full
);

  localparam int unsigned CNT_W = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
  localparam int unsigned ACC_W = CNT_W + 2;
  localparam logic [ACC_W-1:0] ACC_POS_FULL = ACC_W'(VOTE_LEN);
  localparam logic [ACC_W-1:0] ACC_NEG_FULL = ACC_W'(0) - ACC_W'(VOTE_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_close;
  vote_t            r_vote;
  logic             r_full;

  logic             w_count;
  logic             w_last;
  logic [ACC_W-1:0] w_delta;
  logic [ACC_W-1:0] w_acc_nxt;
  vote_t            w_vote_nxt;

  // Accumulator step and window-close detection
  always_comb begin
    w_count = i_en & i_dec_valid;
    w_last  = w_count && (r_cnt == CNT_W'(VOTE_LEN - 1));
    w_delta = '0;
    if (w_count) begin
      case (i_decision)
        DEC_EARLY: w_delta = ACC_W'(1);
        DEC_LATE:  w_delta = '1;
        default:   w_delta = '0;
      endcase
    end
    w_acc_nxt  = r_acc + w_delta;
    w_vote_nxt = VOTE_ZERO;
    if (w_acc_nxt[ACC_W-1]) begin
      w_vote_nxt = VOTE_NEG;
    end else if (w_acc_nxt != '0) begin
      w_vote_nxt = VOTE_POS;
    end
  end

  // Window state; the result is latched on the edge that counts the last decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_close <= 1'b0;
      r_vote  <= VOTE_ZERO;
      r_full  <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_close <= 1'b0;
    end else begin
      r_close <= w_last;
      if (w_last) begin
        r_cnt  <= '0;
        r_acc  <= '0;
        r_vote <= w_vote_nxt;
        r_full <= (w_acc_nxt == ACC_POS_FULL) || (w_acc_nxt == ACC_NEG_FULL);
      end else if (w_count) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= w_acc_nxt;
      end
    end
  end

  assign o_close = r_close;
  assign o_vote  = r_vote;
  assign o_full  = r_full;

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR phase controller: turns windowed early/late votes into a phase
// interpolator code, with a coarse ACQUIRE loop, a fine TRACK loop and a
// saturating frequency integrator that is active only while tracking.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : en / dec_valid / decision in; pi_code / pi_code_valid / locked out
module cdr_phase_ctrl
  import cdr_pkg::*;
#(
  parameter int unsigned VOTE_LEN = 8,
  parameter int unsigned CODE_W   = 7,
  parameter int unsigned ACQ_STEP = 4,
  parameter int unsigned LOCK_WIN = 4,
  parameter int unsigned FREQ_W   = 8,
  parameter int unsigned KI_SHIFT = 4
) (
  input logic             clk,
  input logic             rst,
  cdr_phase_ctrl_if.slave bus
);

  localparam int unsigned BAL_W = $clog2(LOCK_WIN + 1);
  localparam logic [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam logic [FREQ_W-1:0] FREQ_MIN = {1'b1, {(FREQ_W-1){1'b0}}};

  state_t                   r_state;
  logic [BAL_W-1:0]         r_bal_cnt;
  logic                     r_ovl_cnt;
  vote_t                    r_prev_vote;
  logic [CODE_W-1:0]        r_pi_code;
  logic                     r_pi_code_valid;
  logic                     r_locked;
  logic signed [FREQ_W-1:0] r_freq_acc;

  logic                     w_close;
  vote_t                    w_vote;
  logic                     w_full;
  logic                     w_upd;
  logic                     w_balanced;
  state_t                   w_state_nxt;
  logic [BAL_W-1:0]         w_bal_nxt;
  logic                     w_ovl_nxt;
  logic [CODE_W-1:0]        w_step;
  logic [CODE_W-1:0]        w_step_term;
  logic [CODE_W-1:0]        w_freq_term;
  logic [CODE_W-1:0]        w_code_nxt;
  logic [FREQ_W:0]          w_freq_sum;
  logic [FREQ_W-1:0]        w_freq_nxt;

  cdr_vote_window #(
    .VOTE_LEN (VOTE_LEN)
  ) u_vote (
    .clk         (clk),
    .rst         (rst),
    .i_en        (bus.en),
    .i_dec_valid (bus.dec_valid),
    .i_decision  (bus.decision),
    .o_close     (w_close),
    .o_vote      (w_vote),
    .o_full      (w_full)
  );

  // Next state, balance/overload counters, next code and integrator value
  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_bal_cnt;
    w_ovl_nxt   = r_ovl_cnt;

    // en low suppresses an update pending from a window that just closed
    w_upd      = w_close & bus.en;
    w_balanced = (w_vote == VOTE_ZERO) ||
                 ((r_prev_vote != VOTE_ZERO) && (w_vote != r_prev_vote));

    // All terms are taken modulo 2^CODE_W so the code wraps in both directions
    w_step = (r_state == ST_TRACK) ? CODE_W'(1) : CODE_W'(ACQ_STEP);
    case (w_vote)
      VOTE_POS: w_step_term = w_step;
      VOTE_NEG: w_step_term = CODE_W'(0) - w_step;
      default:  w_step_term = '0;
    endcase
    w_freq_term = CODE_W'(r_freq_acc >>> KI_SHIFT);
    w_code_nxt  = r_pi_code + w_step_term + w_freq_term;

    // Saturating integrator: overflow shows as differing top two bits
    w_freq_sum = {r_freq_acc[FREQ_W-1], r_freq_acc} + {{(FREQ_W-1){w_vote[1]}}, w_vote};
    if (w_freq_sum[FREQ_W] != w_freq_sum[FREQ_W-1]) begin
      w_freq_nxt = w_freq_sum[FREQ_W] ? FREQ_MIN : FREQ_MAX;
    end else begin
      w_freq_nxt = w_freq_sum[FREQ_W-1:0];
    end

    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_bal_nxt   = '0;
      w_ovl_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          w_ovl_nxt = 1'b0;
          if (w_upd) begin
            if (!w_balanced) begin
              w_bal_nxt = '0;
            end else if (r_bal_cnt == BAL_W'(LOCK_WIN - 1)) begin
              w_state_nxt = ST_TRACK;
              w_bal_nxt   = '0;
            end else begin
              w_bal_nxt = r_bal_cnt + BAL_W'(1);
            end
          end
        end
        ST_TRACK: begin
          // Two back-to-back saturated windows mean the loop has slipped
          if (w_upd) begin
            if (!w_full) begin
              w_ovl_nxt = 1'b0;
            end else if (r_ovl_cnt) begin
              w_state_nxt = ST_ACQUIRE;
              w_ovl_nxt   = 1'b0;
              w_bal_nxt   = '0;
            end else begin
              w_ovl_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_bal_cnt       <= '0;
      r_ovl_cnt       <= 1'b0;
      r_prev_vote     <= VOTE_ZERO;
      r_pi_code       <= '0;
      r_pi_code_valid <= 1'b0;
      r_locked        <= 1'b0;
      r_freq_acc      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_locked        <= (w_state_nxt == ST_TRACK);
      r_bal_cnt       <= w_bal_nxt;
      r_ovl_cnt       <= w_ovl_nxt;
      r_pi_code_valid <= w_upd;
      if (w_upd) begin
        r_pi_code <= w_code_nxt;
        if (w_vote != VOTE_ZERO) begin
          r_prev_vote <= w_vote;
        end
        if (r_state == ST_TRACK) begin
          r_freq_acc <= w_freq_nxt;
        end
      end
    end
  end

  assign bus.pi_code       = r_pi_code;
  assign bus.pi_code_valid = r_pi_code_valid;
  assign bus.locked        = r_locked;

endmodule

// File: doc/cdr_phase_ctrl.md
CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

Interface
REQ-001 SHALL have parameter VOTE_LEN, 8, number of valid decisions per vote window (power of 2, 2..64).
REQ-002 SHALL have parameter CODE_W, 7, phase-interpolator code width.
REQ-003 SHALL have parameter ACQ_STEP, 4, code step per window in ACQUIRE.
REQ-004 SHALL have parameter LOCK_WIN, 4, consecutive "balanced" windows required to declare lock.
REQ-005 SHALL have parameter FREQ_W, 8, signed frequency-integrator width.
REQ-006 SHALL have parameter KI_SHIFT, 4, arithmetic right shift applied to the frequency integrator.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port en, input, 1, loop enable.
REQ-010 SHALL have port dec_valid, input, 1, decision qualifier.
REQ-011 SHALL have port decision, input, 2, phase-detector output: 2'b10 early, 2'b01 late, 2'b00 none, 2'b11 treated as none.
REQ-012 SHALL have port pi_code, output, CODE_W, interpolator phase code (registered).
REQ-013 SHALL have port pi_code_valid, output, 1, one-cycle pulse in the cycle pi_code takes a new value.
REQ-014 SHALL have port locked, output, 1, high in TRACK state.

Function
REQ-015 A decision SHALL be counted only when en=1 and dec_valid=1; early adds +1, late adds -1 to signed vote_acc; every counted decision increments win_cnt.
REQ-016 The window SHALL close on the edge that counts the VOTE_LEN-th decision; vote = +1 if final vote_acc>0, -1 if <0, 0 if =0; vote_acc and win_cnt SHALL clear at the same edge.
REQ-017 pi_code SHALL update exactly one clock after window close: pi_code + step*vote + (freq_acc >>> KI_SHIFT), modulo 2^CODE_W (wrap both directions, no saturation).
REQ-018 pi_code_valid SHALL pulse on every update, including when vote=0 and the resulting code is unchanged.
REQ-019 step SHALL be ACQ_STEP in ACQUIRE and 1 in TRACK.
REQ-020 FSM states SHALL be IDLE, ACQUIRE, TRACK; IDLE->ACQUIRE on en=1; any state->IDLE on en=0 at the next edge.
REQ-021 A window SHALL be "balanced" if vote=0 or vote is opposite in sign to the previous nonzero vote; ACQUIRE->TRACK after LOCK_WIN consecutive balanced windows; an unbalanced window SHALL reset the balance counter.
REQ-022 TRACK->ACQUIRE when |vote_acc| = VOTE_LEN at close for 2 consecutive windows; the balance counter SHALL clear.
REQ-023 freq_acc SHALL add vote only on window close in TRACK, saturating at +2^(FREQ_W-1)-1 / -2^(FREQ_W-1); it SHALL hold in ACQUIRE and IDLE.
REQ-024 en falling SHALL clear vote_acc, win_cnt and the balance counter and suppress any pending update (en=0 wins over simultaneous window close); pi_code and freq_acc SHALL hold.
REQ-025 locked SHALL be registered and equal (state==TRACK).

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, pi_code 0, pi_code_valid 0, locked 0, freq_acc 0, vote_acc 0, win_cnt 0, balance and overload counters 0, previous-vote 0.
REQ-027 rst asserted mid-window SHALL discard the partial window; first window after release starts at count 0.

Structure
REQ-028 Decision encodings and the FSM state type SHALL live in shared package cdr_pkg.
REQ-029 Window counting and vote generation SHALL be sub-module cdr_vote_window (outputs vote, close pulse, |vote_acc|==VOTE_LEN flag); FSM, integrator and code update stay in cdr_phase_ctrl.

Verification (defaults)
REQ-030 Reset: assert rst mid-operation -> pi_code=0, locked=0, pi_code_valid=0 immediately, before next clk edge.
REQ-031 en=1, 8 early decisions from code 0 -> pi_code=4 one clock after 8th decision, single pi_code_valid pulse.
REQ-032 Wrap: pi_code=124 in ACQUIRE, 8 early -> pi_code=0; then 8 late -> pi_code=124.
REQ-033 Lock: windows alternating 8 early / 8 late -> locked=1 after 4th balanced window; next 5-early/3-late window -> code +1.
REQ-034 Saturation: in TRACK, 130 windows of 5 early/3 late -> freq_acc=127, per-window step = 1+7 = 8; two all-early windows -> locked=0, ACQUIRE.
REQ-035 en dropped on the cycle of the 8th decision -> no pi_code_valid, pi_code unchanged, win_cnt=0 on re-enable.
